rc4_prga_engine: RTL

RC4_PRGA_ENGINE -- requirements
Module: rc4_prga_engine

---
 rtl/rc4_prga_engine.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/rc4_prga_engine.sv
// rc4_prga_engine: RC4 keystream generator decrypting a ciphertext ROM into a plaintext RAM,
// with an optional abort on any non-lowercase/space plaintext byte.
module rc4_prga_engine #(
  parameter int MSG_LEN  = 32,
  parameter int ADDR_W   = 5,
  parameter bit CHECK_EN = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              valid,
  output logic              abort,
  output logic [7:0]        s_addr,
  output logic [7:0]        s_wdata,
  output logic              s_wren,
  input  logic [7:0]        s_rdata,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_rdata,
  output logic [ADDR_W-1:0] out_addr,
  output logic [7:0]        out_wdata,
  output logic              out_wren
);
  localparam logic [3:0] st_idle      = 4'd0;
  localparam logic [3:0] st_check     = 4'd1;
  localparam logic [3:0] st_rd_si     = 4'd2;
  localparam logic [3:0] st_cap_si    = 4'd3;
  localparam logic [3:0] st_rd_sj     = 4'd4;
  localparam logic [3:0] st_cap_sj    = 4'd5;
  localparam logic [3:0] st_wr_i      = 4'd6;
  localparam logic [3:0] st_wr_j      = 4'd7;
  localparam logic [3:0] st_rd_f      = 4'd8;
  localparam logic [3:0] st_cap_f     = 4'd9;
  localparam logic [3:0] st_write_out = 4'd10;
  localparam logic [3:0] st_done      = 4'd11;
  localparam logic [ADDR_W:0] last_k  = (ADDR_W+1)'(MSG_LEN);
  localparam logic [ADDR_W:0] one_k   = (ADDR_W+1)'(1);

  logic [3:0]      state_q, state_d;
  logic [7:0]      i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d, f_q, f_d, c_q, c_d;
  logic [ADDR_W:0] k_q, k_d;
  logic            valid_q, valid_d, abort_q, abort_d;
  logic [7:0]      pt;
  logic            pt_ok;

  assign pt    = f_q ^ c_q;
  assign pt_ok = (pt == 8'h20) || (pt >= 8'h61 && pt <= 8'h7a);
  assign busy  = state_q != st_idle;
  assign done  = state_q == st_done;
  assign valid = valid_q;
  assign abort = abort_q;

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    si_d      = si_q;
    sj_d      = sj_q;
    f_d       = f_q;
    c_d       = c_q;
    k_d       = k_q;
    valid_d   = valid_q;
    abort_d   = abort_q;
    s_addr    = '0;
    s_wdata   = '0;
    s_wren    = 1'b0;
    rom_addr  = '0;
    out_addr  = '0;
    out_wdata = '0;
    out_wren  = 1'b0;
    case (state_q)
      st_idle: if (start) begin
        i_d     = '0;
        j_d     = '0;
        k_d     = '0;
        valid_d = 1'b0;
        abort_d = 1'b0;
        state_d = st_check;
      end
      st_check: if (k_q == last_k) begin
        valid_d = 1'b1;
        state_d = st_done;
      end else begin
        i_d     = i_q + 8'd1;
        state_d = st_rd_si;
      end
      st_rd_si: begin
        s_addr  = i_q;
        state_d = st_cap_si;
      end
      st_cap_si: begin
        s_addr  = i_q;
        si_d    = s_rdata;
        j_d     = j_q + s_rdata;
        state_d = st_rd_sj;
      end
      st_rd_sj: begin
        s_addr  = j_q;
        state_d = st_cap_sj;
      end
      st_cap_sj: begin
        s_addr  = j_q;
        sj_d    = s_rdata;
        state_d = st_wr_i;
      end
      st_wr_i: begin
        s_addr  = i_q;
        s_wdata = sj_q;
        s_wren  = 1'b1;
        state_d = st_wr_j;
      end
      // Writing si last makes the i==j case leave s[i] unchanged.
      st_wr_j: begin
        s_addr  = j_q;
        s_wdata = si_q;
        s_wren  = 1'b1;
        state_d = st_rd_f;
      end
      st_rd_f: begin
        s_addr   = si_q + sj_q;
        rom_addr = k_q[ADDR_W-1:0];
        state_d  = st_cap_f;
      end
      st_cap_f: begin
        s_addr   = si_q + sj_q;
        rom_addr = k_q[ADDR_W-1:0];
        f_d      = s_rdata;
        c_d      = rom_rdata;
        state_d  = st_write_out;
      end
      st_write_out: begin
        out_addr  = k_q[ADDR_W-1:0];
        out_wdata = pt;
        if (CHECK_EN && !pt_ok) begin
          abort_d = 1'b1;
          state_d = st_done;
        end else begin
          out_wren = 1'b1;
          k_d      = k_q + one_k;
          state_d  = st_check;
        end
      end
      st_done: state_d = st_idle;
      default: state_d = st_idle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= st_idle;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      f_q     <= '0;
      c_q     <= '0;
      k_q     <= '0;
      valid_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      f_q     <= f_d;
      c_q     <= c_d;
      k_q     <= k_d;
      valid_q <= valid_d;
      abort_q <= abort_d;
    end
  end
endmodule
